// File: rtl/match_controller.sv
// Round/match sequencer: INTRO -> FIGHT -> KO rounds up to a best-of match result,
// with hold-to-restart. Optional SUDDEN_DEATH_EN keeps timeout ties in FIGHT.
module match_controller #(
  parameter int NUM_PLAYERS   = 2,
  parameter int HP_W          = 9,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ROUND_TICKS   = 1800,
  parameter int INTRO_TICKS   = 40,
  parameter int KO_TICKS      = 40,
  parameter int HOLD_TICKS    = 40
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        tick,
  input  logic [NUM_PLAYERS*HP_W-1:0] health,
  input  logic                        reset_req,
  output logic [1:0]                  state,
  output logic                        fight_enable,
  output logic                        round_reset,
  output logic [3:0]                  round_num,
  output logic [10:0]                 time_left,
  output logic [NUM_PLAYERS*2-1:0]    wins,
  output logic [2:0]                  round_winner,
  output logic                        round_draw,
  output logic [2:0]                  match_winner
);

  typedef enum logic [1:0] {
    S_INTRO = 2'd0,
    S_FIGHT = 2'd1,
    S_KO    = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t                     r_state;
  logic [15:0]                r_phase_cnt;
  logic [15:0]                r_hold;
  logic                       r_start;
  logic                       r_round_reset;
  logic                       r_fight_en;
  logic [3:0]                 r_round_num;
  logic [10:0]                r_time_left;
  logic [NUM_PLAYERS*2-1:0]   r_wins;
  logic [2:0]                 r_round_winner;
  logic                       r_round_draw;
  logic [2:0]                 r_match_winner;

  logic [2:0]      w_alive_cnt;
  logic [2:0]      w_alive_idx;
  logic [HP_W-1:0] w_max_hp;
  logic [2:0]      w_max_cnt;
  logic [2:0]      w_max_idx;
  logic            w_judge_end;
  logic            w_judge_draw;
  logic [2:0]      w_judge_idx;
  logic            w_match_done;
  logic [2:0]      w_match_idx;
  logic            w_restart;

  always_comb begin
    w_alive_cnt = '0;
    w_alive_idx = '0;
    w_max_hp    = '0;
    w_max_cnt   = '0;
    w_max_idx   = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (health[k*HP_W +: HP_W] != '0) begin
        w_alive_cnt = w_alive_cnt + 3'd1;
        w_alive_idx = 3'(k);
      end
      if (health[k*HP_W +: HP_W] > w_max_hp) begin
        w_max_hp  = health[k*HP_W +: HP_W];
        w_max_cnt = 3'd1;
        w_max_idx = 3'(k);
      end else if (health[k*HP_W +: HP_W] == w_max_hp) begin
        w_max_cnt = w_max_cnt + 3'd1;
      end
    end
  end

  // Round judging in priority order: nobody alive, last survivor, timeout.
  always_comb begin
    w_judge_end  = 1'b0;
    w_judge_draw = 1'b0;
    w_judge_idx  = '0;
    if (w_alive_cnt == 3'd0) begin
      w_judge_end  = 1'b1;
      w_judge_draw = 1'b1;
    end else if (w_alive_cnt == 3'd1) begin
      w_judge_end = 1'b1;
      w_judge_idx = w_alive_idx;
    end else if (r_time_left == '0) begin
      if (w_max_cnt == 3'd1) begin
        w_judge_end = 1'b1;
        w_judge_idx = w_max_idx;
      end else begin
`ifdef SUDDEN_DEATH_EN
        w_judge_end  = 1'b0;
`else
        w_judge_end  = 1'b1;
        w_judge_draw = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    w_match_done = 1'b0;
    w_match_idx  = '0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      if (r_wins[k*2 +: 2] == 2'(ROUNDS_TO_WIN)) begin
        w_match_done = 1'b1;
        w_match_idx  = 3'(k);
      end
    end
  end

  assign w_restart = tick && reset_req && (r_hold == 16'(HOLD_TICKS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_INTRO;
      r_phase_cnt    <= '0;
      r_hold         <= '0;
      r_start        <= 1'b1;
      r_round_reset  <= 1'b0;
      r_fight_en     <= 1'b0;
      r_round_num    <= 4'd1;
      r_time_left    <= 11'(ROUND_TICKS);
      r_wins         <= '0;
      r_round_winner <= '0;
      r_round_draw   <= 1'b0;
      r_match_winner <= '0;
    end else begin
      r_start       <= 1'b0;
      r_round_reset <= r_start;

      // Hold counter saturates so a long hold restarts only once.
      if (!reset_req) begin
        r_hold <= '0;
      end else if (tick && r_hold != 16'(HOLD_TICKS)) begin
        r_hold <= r_hold + 16'd1;
      end

      if (w_restart) begin
        r_state        <= S_INTRO;
        r_phase_cnt    <= '0;
        r_round_reset  <= 1'b1;
        r_fight_en     <= 1'b0;
        r_round_num    <= 4'd1;
        r_time_left    <= 11'(ROUND_TICKS);
        r_wins         <= '0;
        r_round_winner <= '0;
        r_round_draw   <= 1'b0;
        r_match_winner <= '0;
      end else if (tick) begin
        case (r_state)
          S_INTRO: begin
            if (r_phase_cnt == 16'(INTRO_TICKS - 1)) begin
              r_phase_cnt <= '0;
              r_state     <= S_FIGHT;
              r_fight_en  <= 1'b1;
            end else begin
              r_phase_cnt <= r_phase_cnt + 16'd1;
            end
          end
          S_FIGHT: begin
            if (w_judge_end) begin
              r_state     <= S_KO;
              r_fight_en  <= 1'b0;
              r_phase_cnt <= '0;
              if (w_judge_draw) begin
                r_round_draw   <= 1'b1;
                r_round_winner <= '0;
              end else begin
                r_round_draw   <= 1'b0;
                r_round_winner <= w_judge_idx + 3'd1;
                for (int k = 0; k < NUM_PLAYERS; k++) begin
                  if (3'(k) == w_judge_idx && r_wins[k*2 +: 2] != 2'd3) begin
                    r_wins[k*2 +: 2] <= r_wins[k*2 +: 2] + 2'd1;
                  end
                end
              end
            end else if (r_time_left != '0) begin
              r_time_left <= r_time_left - 11'd1;
            end
          end
          S_KO: begin
            if (r_phase_cnt == 16'(KO_TICKS - 1)) begin
              r_phase_cnt <= '0;
              if (w_match_done) begin
                r_state        <= S_OVER;
                r_match_winner <= w_match_idx + 3'd1;
              end else begin
                r_state       <= S_INTRO;
                r_round_reset <= 1'b1;
                r_time_left   <= 11'(ROUND_TICKS);
                if (r_round_num != 4'd15) begin
                  r_round_num <= r_round_num + 4'd1;
                end
              end
            end else begin
              r_phase_cnt <= r_phase_cnt + 16'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign state        = r_state;
  assign fight_enable = r_fight_en;
  assign round_reset  = r_round_reset;
  assign round_num    = r_round_num;
  assign time_left    = r_time_left;
  assign wins         = r_wins;
  assign round_winner = r_round_winner;
  assign round_draw   = r_round_draw;
  assign match_winner = r_match_winner;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller (ROUND_TICKS=50); expectations are hand-computed
// per directed step, pushed to a queue and compared by an independent monitor.
module tb_match_controller;

  localparam int ST_INTRO = 0;
  localparam int ST_FIGHT = 1;
  localparam int ST_KO    = 2;
  localparam int ST_OVER  = 3;

  logic        clk;
  logic        reset_n;
  logic        tick;
  logic [17:0] health;
  logic        reset_req;
  logic [1:0]  state;
  logic        fight_enable;
  logic        round_reset;
  logic [3:0]  round_num;
  logic [10:0] time_left;
  logic [3:0]  wins;
  logic [2:0]  round_winner;
  logic        round_draw;
  logic [2:0]  match_winner;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       fe;
    logic [3:0] rn;
    logic [10:0] tl;
    logic [3:0] w;
    logic [2:0] rw;
    logic       rd;
    logic [2:0] mw;
    int         rr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   rrSeen = 0;

  logic [3:0] expW;
  logic [2:0] expRw;
  logic       expRd;

  match_controller #(.ROUND_TICKS(50)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .health       (health),
    .reset_req    (reset_req),
    .state        (state),
    .fight_enable (fight_enable),
    .round_reset  (round_reset),
    .round_num    (round_num),
    .time_left    (time_left),
    .wins         (wins),
    .round_winner (round_winner),
    .round_draw   (round_draw),
    .match_winner (match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic setHealth(input logic [8:0] p1, input logic [8:0] p2);
    health = {p2, p1};
  endtask

  task automatic checkOutput(input string name, input int st, input logic fe, input int rn,
                             input int tl, input logic [3:0] w, input int rw, input logic rd,
                             input int mw, input int rr);
    exp_t e;
    e.name = name; e.st = 2'(st); e.fe = fe; e.rn = 4'(rn); e.tl = 11'(tl);
    e.w = w; e.rw = 3'(rw); e.rd = rd; e.mw = 3'(mw); e.rr = rr;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: counts round_reset pulses and compares pending expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        if (round_reset) rrSeen++;
        while (q.size() > 0) begin
          e = q.pop_front();
          checks++;
          if (state !== e.st || fight_enable !== e.fe || round_num !== e.rn ||
              time_left !== e.tl || wins !== e.w || round_winner !== e.rw ||
              round_draw !== e.rd || match_winner !== e.mw || rrSeen != e.rr) begin
            errors++;
            $display("[TB] FAIL %s: got st=%0d fe=%0d rn=%0d tl=%0d w=%b rw=%0d rd=%0d mw=%0d rr=%0d, expected st=%0d fe=%0d rn=%0d tl=%0d w=%b rw=%0d rd=%0d mw=%0d rr=%0d",
                     e.name, state, fight_enable, round_num, time_left, wins, round_winner,
                     round_draw, match_winner, rrSeen, e.st, e.fe, e.rn, e.tl, e.w, e.rw,
                     e.rd, e.mw, e.rr);
          end
        end
      end
    end
  end

  initial begin
    tick = 1'b0;
    reset_req = 1'b0;
    reset_n = 1'b0;
    setHealth(150, 150);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    checkOutput("reset",      ST_INTRO, 0, 1, 50, 4'b0000, 0, 0, 0, 1);
    applyStimulus(39);
    checkOutput("intro39",    ST_INTRO, 0, 1, 50, 4'b0000, 0, 0, 0, 1);
    applyStimulus(1);
    checkOutput("fight_entry", ST_FIGHT, 1, 1, 50, 4'b0000, 0, 0, 0, 1);
    applyStimulus(10);
    checkOutput("r1_running", ST_FIGHT, 1, 1, 40, 4'b0000, 0, 0, 0, 1);
    setHealth(150, 0);
    applyStimulus(1);
    checkOutput("r1_ko",      ST_KO,    0, 1, 40, 4'b0001, 1, 0, 0, 1);
    applyStimulus(39);
    checkOutput("ko39",       ST_KO,    0, 1, 40, 4'b0001, 1, 0, 0, 1);
    applyStimulus(1);
    checkOutput("r2_intro",   ST_INTRO, 0, 2, 50, 4'b0001, 1, 0, 0, 2);

    setHealth(120, 80);
    applyStimulus(40);
    checkOutput("r2_fight",   ST_FIGHT, 1, 2, 50, 4'b0001, 1, 0, 0, 2);
    applyStimulus(50);
    checkOutput("r2_tl0",     ST_FIGHT, 1, 2, 0,  4'b0001, 1, 0, 0, 2);
    applyStimulus(1);
    checkOutput("r2_timeout", ST_KO,    0, 2, 0,  4'b0010, 1, 0, 0, 2);
    applyStimulus(40);
    checkOutput("match_over", ST_OVER,  0, 2, 0,  4'b0010, 1, 0, 1, 2);
    setHealth(0, 0);
    applyStimulus(10);
    checkOutput("over_frozen", ST_OVER, 0, 2, 0,  4'b0010, 1, 0, 1, 2);

    reset_req = 1'b1;
    applyStimulus(39);
    checkOutput("hold39",     ST_OVER,  0, 2, 0,  4'b0010, 1, 0, 1, 2);
    applyStimulus(1);
    checkOutput("restart1",   ST_INTRO, 0, 1, 50, 4'b0000, 0, 0, 0, 3);
    setHealth(150, 100);
    applyStimulus(160);
    checkOutput("hold200",    ST_INTRO, 0, 2, 50, 4'b0001, 1, 0, 0, 4);
    reset_req = 1'b0;
    applyStimulus(1);
    reset_req = 1'b1;
    applyStimulus(39);
    checkOutput("rehold39",   ST_FIGHT, 1, 2, 21, 4'b0001, 1, 0, 0, 4);
    applyStimulus(1);
    checkOutput("restart2",   ST_INTRO, 0, 1, 50, 4'b0000, 0, 0, 0, 5);
    reset_req = 1'b0;

    setHealth(100, 100);
    applyStimulus(40);
    checkOutput("tie_fight",  ST_FIGHT, 1, 1, 50, 4'b0000, 0, 0, 0, 5);
    applyStimulus(51);
`ifdef SUDDEN_DEATH_EN
    checkOutput("tie_sd",     ST_FIGHT, 1, 1, 0,  4'b0000, 0, 0, 0, 5);
    applyStimulus(3);
    checkOutput("tie_sd_hold", ST_FIGHT, 1, 1, 0, 4'b0000, 0, 0, 0, 5);
    setHealth(100, 90);
    applyStimulus(1);
    checkOutput("sd_ko",      ST_KO,    0, 1, 0,  4'b0001, 1, 0, 0, 5);
    expW = 4'b0001; expRw = 3'd1; expRd = 1'b0;
`else
    checkOutput("tie_draw",   ST_KO,    0, 1, 0,  4'b0000, 0, 1, 0, 5);
    expW = 4'b0000; expRw = 3'd0; expRd = 1'b1;
`endif
    applyStimulus(40);
    checkOutput("r_after_tie", ST_INTRO, 0, 2, 50, expW, int'(expRw), expRd, 0, 6);

    setHealth(100, 100);
    applyStimulus(45);
    checkOutput("r3_running", ST_FIGHT, 1, 2, 45, expW, int'(expRw), expRd, 0, 6);
    setHealth(0, 0);
    applyStimulus(1);
    checkOutput("double_ko",  ST_KO,    0, 2, 45, expW, 0, 1, 0, 6);

    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
